// File: rtl/rv32i_types.sv
// Shared types for the instruction fetch path.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // One buffered fetch: the PC it came from and the instruction word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int          FETCH_ENTRY_W = $bits(fetch_entry_t);
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries.
// Latency: a push is visible at dout the cycle after it is written; dout is the head, read combinationally.
// Backpressure: push while full and pop while empty are ignored; flush empties it in one cycle.
//
// Ports: clk, rst (sync, active-high); push/din write; pop advances the head;
// flush drops all entries; full/empty/count report occupancy; dout is the head (zero when empty).
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         dout
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_FULL);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Head is driven to zero when empty so the consumer never sees stale words.
    assign dout = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word reads to imem and buffers {pc, inst} for the instruction register.
// Latency: one cycle from imem_resp to ir_valid; ir_inst/ir_pc show the buffer head directly.
// Backpressure: a new read is issued only while the buffer has room; ir_ready pops the head.
//
// Ports: clk, rst (sync, active-high); imem_addr/imem_read request, imem_resp/imem_rdata response;
// redirect/redirect_pc flush and restart; ir_ready consumer load, ir_valid/ir_inst/ir_pc buffer head.
module fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        ir_ready,
    output logic        ir_valid,
    output logic [31:0] ir_inst,
    output logic [31:0] ir_pc
);

    localparam int           CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_addr;

    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic          w_has_room;
    fetch_entry_t  w_fifo_din;
    fetch_entry_t  w_fifo_dout;

    assign w_has_room = (w_fifo_count < DEPTH_CNT);

    // State register plus the fetch/request address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (redirect) begin
                r_fetch_pc <= align_pc(redirect_pc);
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            // The request address is latched once, so it stays put through DISCARD
            // even though fetch_pc has already moved to the redirect target.
            if ((r_state == IDLE) && (w_state_nxt == REQ)) begin
                r_req_addr <= r_fetch_pc;
            end
        end
    end

    // Next-state logic. A response always closes the outstanding read, even when a
    // redirect arrives with it; the data is simply not pushed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!redirect && w_has_room) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (imem_resp) begin
                    w_state_nxt = IDLE;
                end else if (redirect) begin
                    w_state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_resp) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / control decode.
    always_comb begin
        imem_read = (r_state == REQ) || (r_state == DISCARD);
        w_push    = (r_state == REQ) && imem_resp && !redirect && !w_fifo_full;
        w_pop     = !w_fifo_empty && ir_ready && !redirect;
        w_flush   = redirect;
    end

    assign imem_addr       = r_req_addr;
    assign w_fifo_din.pc   = r_fetch_pc;
    assign w_fifo_din.inst = imem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_fifo_din),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count),
        .dout  (w_fifo_dout)
    );

    assign ir_valid = !w_fifo_empty;
    assign ir_inst  = w_fifo_dout.inst;
    assign ir_pc    = w_fifo_dout.pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic        imem_resp = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ir_ready;
    logic        ir_valid;
    logic [31:0] ir_inst;
    logic [31:0] ir_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0060),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_read   (imem_read),
        .imem_resp   (imem_resp),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir_ready    (ir_ready),
        .ir_valid    (ir_valid),
        .ir_inst     (ir_inst),
        .ir_pc       (ir_pc)
    );

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 0;
    int          wait_cnt = 0;
    bit          tainted = 1'b0;
    bit          prev_read = 1'b0;
    bit          prev_resp = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [63:0] exp_q[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (a == 32'h60) return 32'h0000_0013;
        return {a[23:0], 8'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory model + scoreboard. A response is expected at ir_* only if no redirect
    // hit its request while outstanding or in the response cycle itself.
    always @(negedge clk) begin
        logic [63:0] e;
        imem_resp = 1'b0;
        if (rst) begin
            exp_q.delete();
            tainted   = 1'b0;
            wait_cnt  = 0;
            prev_read = 1'b0;
            prev_resp = 1'b0;
        end else begin
            if (prev_read && imem_read && !prev_resp)
                check("addr_stable", imem_addr, prev_addr);
            check("sb_valid", {31'b0, ir_valid}, {31'b0, exp_q.size() != 0});
            if (ir_valid && ir_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=pop required=no_entry");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", ir_pc, e[63:32]);
                    check("sb_inst", ir_inst, e[31:0]);
                end
            end
            if (redirect) exp_q.delete();
            if (imem_read) begin
                if (wait_cnt >= mem_lat) begin
                    imem_resp  = 1'b1;
                    imem_rdata = inst_of(imem_addr);
                    if (!redirect && !tainted) exp_q.push_back({imem_addr, imem_rdata});
                    tainted  = 1'b0;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                    if (redirect) tainted = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
            prev_read = imem_read;
            prev_addr = imem_addr;
            prev_resp = imem_resp;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; holds rst for two edges and checks the state in between.
    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_read", {31'b0, imem_read}, 32'd0);
        check("rst_valid", {31'b0, ir_valid}, 32'd0);
        check("rst_addr", imem_addr, 32'h60);
        check("rst_ir_pc", ir_pc, 32'h0);
        check("rst_ir_inst", ir_inst, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rdy;
        logic        rd;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t vt[9];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        bit          saw;

        // Cycle-by-cycle expectations after reset with a 2-cycle memory and ir_ready=1.
        vt[0] = '{1'b1, 1'b0, 32'h60, 1'b0, 32'h0,  32'h0};
        vt[1] = '{1'b1, 1'b1, 32'h60, 1'b0, 32'h0,  32'h0};
        vt[2] = '{1'b1, 1'b1, 32'h60, 1'b0, 32'h0,  32'h0};
        vt[3] = '{1'b1, 1'b1, 32'h60, 1'b0, 32'h0,  32'h0};
        vt[4] = '{1'b1, 1'b0, 32'h60, 1'b1, 32'h60, 32'h13};
        vt[5] = '{1'b1, 1'b1, 32'h64, 1'b0, 32'h0,  32'h0};
        vt[6] = '{1'b1, 1'b1, 32'h64, 1'b0, 32'h0,  32'h0};
        vt[7] = '{1'b1, 1'b1, 32'h64, 1'b0, 32'h0,  32'h0};
        vt[8] = '{1'b1, 1'b0, 32'h64, 1'b1, 32'h64, 32'h0000_6413};

        redirect_pc = 32'h0;
        ir_ready    = 1'b0;
        mem_lat     = 2;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            ir_ready = vt[i].rdy;
            @(negedge clk);
            check($sformatf("v%0d_read", i), {31'b0, imem_read}, {31'b0, vt[i].rd});
            if (vt[i].rd) check($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
            check($sformatf("v%0d_valid", i), {31'b0, ir_valid}, {31'b0, vt[i].vld});
            if (vt[i].vld) begin
                check($sformatf("v%0d_pc", i), ir_pc, vt[i].pc);
                check($sformatf("v%0d_inst", i), ir_inst, vt[i].inst);
            end
            next_cyc();
        end

        // Zero-wait memory, consumer stalled: buffer fills to exactly two entries.
        mem_lat  = 0;
        ir_ready = 1'b0;
        do_reset();
        repeat (4) next_cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_read", {31'b0, imem_read}, 32'd0);
            check("full_valid", {31'b0, ir_valid}, 32'd1);
            check("full_pc", ir_pc, 32'h60);
            next_cyc();
        end
        ir_ready = 1'b1;
        @(negedge clk);
        check("drain0_pc", ir_pc, 32'h60);
        next_cyc();
        @(negedge clk);
        check("drain1_pc", ir_pc, 32'h64);
        next_cyc();
        @(negedge clk);
        check("drain2_valid", {31'b0, ir_valid}, 32'd0);
        check("drain2_read", {31'b0, imem_read}, 32'd1);
        check("drain2_addr", imem_addr, 32'h68);
        next_cyc();
        // Redirect while the head is being consumed: pop discarded, buffer flushed.
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        check("drain3_pc", ir_pc, 32'h68);
        next_cyc();
        redirect = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'b0, ir_valid}, 32'd0);
        next_cyc();
        @(negedge clk);
        check("flush_read", {31'b0, imem_read}, 32'd1);
        check("flush_addr", imem_addr, 32'h300);
        next_cyc();

        // Redirect while a 3-cycle read is outstanding: that response must be dropped.
        mem_lat  = 3;
        ir_ready = 1'b1;
        do_reset();
        next_cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        check("rd1_addr", imem_addr, 32'h60);
        next_cyc();
        redirect = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rd1_valid", {31'b0, ir_valid}, 32'd0);
            if (i < 3) begin
                check("rd1_disc_read", {31'b0, imem_read}, 32'd1);
                check("rd1_disc_addr", imem_addr, 32'h60);
            end
            if (i == 4) begin
                check("rd1_new_read", {31'b0, imem_read}, 32'd1);
                check("rd1_new_addr", imem_addr, 32'h100);
            end
            next_cyc();
        end
        @(negedge clk);
        check("rd1_arr_valid", {31'b0, ir_valid}, 32'd1);
        check("rd1_arr_pc", ir_pc, 32'h100);
        check("rd1_arr_inst", ir_inst, 32'h0001_0013);
        next_cyc();

        // Redirect to an unaligned PC in the same cycle as the response.
        mem_lat = 1;
        do_reset();
        next_cyc();
        next_cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        @(negedge clk);
        check("rd2_read", {31'b0, imem_read}, 32'd1);
        next_cyc();
        redirect = 1'b0;
        @(negedge clk);
        check("rd2_valid", {31'b0, ir_valid}, 32'd0);
        check("rd2_idle", {31'b0, imem_read}, 32'd0);
        next_cyc();
        @(negedge clk);
        check("rd2_new_read", {31'b0, imem_read}, 32'd1);
        check("rd2_new_addr", imem_addr, 32'h200);
        next_cyc();
        next_cyc();
        @(negedge clk);
        check("rd2_arr_pc", ir_pc, 32'h200);
        next_cyc();

        // Push and pop together at occupancy 1: consumer loads only in response cycles.
        mem_lat  = 0;
        ir_ready = 1'b0;
        do_reset();
        exp_pc = 32'h60;
        for (int i = 0; i < 14; i++) begin
            ir_ready = imem_read;
            @(negedge clk);
            if (i >= 2) begin
                check("pp_valid", {31'b0, ir_valid}, 32'd1);
                check("pp_pc", ir_pc, exp_pc);
            end
            if (ir_valid && ir_ready) exp_pc = exp_pc + 32'd4;
            next_cyc();
        end
        check("pp_handshakes", exp_pc, 32'h78);

        // Reset in the middle of a request abandons it and restarts at RESET_PC.
        mem_lat  = 6;
        ir_ready = 1'b0;
        saw      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_read) begin
                saw = 1'b1;
                break;
            end
            next_cyc();
        end
        check("pre_rst_req", {31'b0, saw}, 32'd1);
        next_cyc();
        do_reset();
        next_cyc();
        @(negedge clk);
        check("post_rst_read", {31'b0, imem_read}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h60);
        next_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
